adder_5: RTL and testbench

Clocked 5-bit binary adder with carry-in, carry-out and two's-complement overflow flag. Callers perform subtraction by presenting the one's complement of the subtrahend on `b` with `cin = 1`; the block itself only adds. It sits in the arithmetic datapath and registers every result, so downstream logic sees stable, glitch-free sum and flags one cycle after the operands are accepted.

---
 rtl/adder_5.sv | 47 ++++
 tb/tb_adder_5.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_5.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// Results appear one cycle after in_valid; out_valid marks each new result.
module adder_5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic             ov,
  output logic [WIDTH-1:0] s,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= c[WIDTH];
        ov   <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_5.sv
// Directed and exhaustive self-checking bench for adder_5.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_adder_5;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic         cout, ov, out_valid;
  logic [W-1:0] s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ov;
  } vec_t;

  adder_5 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .cout(cout), .ov(ov), .s(s), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                              input logic [W-1:0] vs, input logic vco, input logic vov);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.s = vs; v.cout = vco; v.ov = vov;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Load a nonzero result so the async clear is observable.
    a = 5'b00110; b = 5'b00001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, cout, ov, s} !== {1'b1, 1'b0, 1'b0, 5'b00111}) begin
      n_fail++;
      $display("FAIL reset_preload: got v=%b c=%b o=%b s=%b want v=1 c=0 o=0 s=00111",
               out_valid, cout, ov, s);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, cout, ov, s} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b c=%b o=%b s=%b want all 0", out_valid, cout, ov, s);
    end
    in_valid = 1'b1; a = 5'b11111; b = 5'b11111; cin = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, cout, ov, s} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b c=%b o=%b s=%b want all 0", out_valid, cout, ov, s);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, cout, ov, s} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b c=%b o=%b s=%b want all 0", out_valid, cout, ov, s);
    end
    cin = 1'b0;
  endtask

  task automatic test_reset_discard();
    in_valid = 1'b1; a = 5'b01010; b = 5'b00101; cin = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, cout, ov, s} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got v=%b c=%b o=%b s=%b want all 0", out_valid, cout, ov, s);
    end
  endtask

  task automatic test_add();
    vec_t v[4];
    v[0] = mk(5'b00110, 5'b00001, 1'b0, 5'b00111, 1'b0, 1'b0);
    v[1] = mk(5'b00010, 5'b01111, 1'b0, 5'b10001, 1'b0, 1'b1);
    v[2] = mk(5'b11101, 5'b00100, 1'b0, 5'b00001, 1'b1, 1'b0);
    v[3] = mk(5'b11011, 5'b10011, 1'b1, 5'b01111, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = v[i].a; b = v[i].b; cin = v[i].cin; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, cout, ov, s} !== {1'b1, v[i].cout, v[i].ov, v[i].s}) begin
        n_fail++;
        $display("FAIL add[%0d]: got v=%b c=%b o=%b s=%b want v=1 c=%b o=%b s=%b",
                 i, out_valid, cout, ov, s, v[i].cout, v[i].ov, v[i].s);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[4];
    v[0] = mk(5'b00110, 5'b11110, 1'b1, 5'b00101, 1'b1, 1'b0);
    v[1] = mk(5'b00010, 5'b10000, 1'b1, 5'b10011, 1'b0, 1'b0);
    v[2] = mk(5'b11101, 5'b11011, 1'b1, 5'b11001, 1'b1, 1'b0);
    v[3] = mk(5'b11011, 5'b01100, 1'b0, 5'b00111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = v[i].a; b = v[i].b; cin = v[i].cin; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, cout, ov, s} !== {1'b1, v[i].cout, v[i].ov, v[i].s}) begin
        n_fail++;
        $display("FAIL sub[%0d]: got v=%b c=%b o=%b s=%b want v=1 c=%b o=%b s=%b",
                 i, out_valid, cout, ov, s, v[i].cout, v[i].ov, v[i].s);
      end
    end
  endtask

  task automatic test_hold();
    a = 5'b00110; b = 5'b00001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 5'b11111; b = 5'b11111; cin = 1'b1; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, s} !== {1'b1, 5'b00111}) begin
      n_fail++;
      $display("FAIL hold_load: got v=%b s=%b want v=1 s=00111", out_valid, s);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, cout, ov, s} !== {1'b0, 1'b0, 1'b0, 5'b00111}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b c=%b o=%b s=%b want v=0 c=0 o=0 s=00111",
                 i, out_valid, cout, ov, s);
      end
    end
  endtask

  task automatic test_boundary();
    vec_t v[3];
    v[0] = mk(5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b0);
    v[1] = mk(5'b01111, 5'b00000, 1'b1, 5'b10000, 1'b0, 1'b1);
    v[2] = mk(5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = v[i].a; b = v[i].b; cin = v[i].cin; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, cout, ov, s} !== {1'b1, v[i].cout, v[i].ov, v[i].s}) begin
        n_fail++;
        $display("FAIL boundary[%0d]: got v=%b c=%b o=%b s=%b want v=1 c=%b o=%b s=%b",
                 i, out_valid, cout, ov, s, v[i].cout, v[i].ov, v[i].s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa, pb, es;
    logic         pc, ec, eo;
    logic [W:0]   tot;
    pa = '0; pb = '0; pc = 1'b0;
    for (int n = 0; n <= 2048; n++) begin
      if (n > 0) begin
        tot = {1'b0, pa} + {1'b0, pb} + {{W{1'b0}}, pc};
        es  = tot[W-1:0];
        ec  = tot[W];
        eo  = (pa[W-1] == pb[W-1]) && (es[W-1] != pa[W-1]);
        n_checks++;
        if ({out_valid, ec, eo, es} !== {out_valid, cout, ov, s} || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL exhaustive a=%b b=%b cin=%b: got v=%b c=%b o=%b s=%b want v=1 c=%b o=%b s=%b",
                   pa, pb, pc, out_valid, cout, ov, s, ec, eo, es);
        end
      end
      if (n < 2048) begin
        {pa, pb, pc} = n[2*W:0];
        a = pa; b = pb; cin = pc; in_valid = 1'b1;
        @(negedge clk);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_discard();
    test_add();
    test_sub();
    test_hold();
    test_boundary();
    test_back_to_back();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
